dtg_param: RTL

// - Parametrised VGA display timing generator; next generation of dtg.
// - Runs from the 100MHz sysclk with an internal pixel-enable divider, so no DCM/clk25 domain is needed.
// - Drives Hsync/Vsync, video_on and pixel row/column to the colorizer and video_game_controller.
// - Adds frame/line strobes, a frame counter and scaled (>>SCALE_SHIFT) coordinates, replacing the top-level shifts.

---
 rtl/dtg_param.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dtg_param.sv
// Parametrised VGA display timing generator clocked from sysclk with an internal pixel-enable divider.
// Optional define DTG_PIPE_ALIGN_EN delays syncs and video_on by one extra pixel period.
module dtg_param #(
    parameter int       H_ACTIVE    = 640,
    parameter int       H_FP        = 16,
    parameter int       H_SYNC      = 96,
    parameter int       H_BP        = 48,
    parameter int       V_ACTIVE    = 480,
    parameter int       V_FP        = 10,
    parameter int       V_SYNC      = 2,
    parameter int       V_BP        = 33,
    parameter logic     SYNC_POL    = 1'b0,
    parameter int       CLK_DIV     = 4,
    parameter int       CNT_W       = 10,
    parameter int       SCALE_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             horiz_sync,
    output logic             vert_sync,
    output logic             video_on,
    output logic             pix_en,
    output logic [CNT_W-1:0] pixel_column,
    output logic [CNT_W-1:0] pixel_row,
    output logic [CNT_W-1:0] col_scaled,
    output logic [CNT_W-1:0] row_scaled,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC;
    localparam int DIV_W   = 5;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0] colsc_q, rowsc_q;
    logic [7:0]       fc_q, fc_d;
    logic             hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;
    logic             pix_q, ls_q, ls_d, fs_q, fs_d;
    logic             tick, col_wrap, row_wrap;

    assign tick     = en && (div_q == DIV_W'(CLK_DIV - 1));
    assign col_wrap = (col_q == CNT_W'(H_TOTAL - 1));
    assign row_wrap = (row_q == CNT_W'(V_TOTAL - 1));

    // Next counter values; zone decode uses them so outputs register alongside the counters.
    always_comb begin
        div_d = div_q;
        col_d = col_q;
        row_d = row_q;
        fc_d  = fc_q;
        if (en) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            if (col_wrap) begin
                col_d = '0;
                if (row_wrap) begin
                    row_d = '0;
                    fc_d  = fc_q + 8'd1;
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
        hs_d  = (col_d >= CNT_W'(H_SS) && col_d < CNT_W'(H_SE)) ? SYNC_POL : ~SYNC_POL;
        vs_d  = (row_d >= CNT_W'(V_SS) && row_d < CNT_W'(V_SE)) ? SYNC_POL : ~SYNC_POL;
        vid_d = (col_d < CNT_W'(H_ACTIVE)) && (row_d < CNT_W'(V_ACTIVE));
        ls_d  = tick && col_wrap;
        fs_d  = tick && col_wrap && row_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            colsc_q <= '0;
            rowsc_q <= '0;
            fc_q    <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            vid_q   <= 1'b0;
            pix_q   <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q <= div_d;
            pix_q <= tick;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
            if (tick) begin
                col_q   <= col_d;
                row_q   <= row_d;
                colsc_q <= col_d >> SCALE_SHIFT;
                rowsc_q <= row_d >> SCALE_SHIFT;
                fc_q    <= fc_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                vid_q   <= vid_d;
            end
        end
    end

`ifdef DTG_PIPE_ALIGN_EN
    // Extra pixel-period stage so syncs line up with a registered colour lookup.
    logic hs_p_q, vs_p_q, vid_p_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_p_q  <= ~SYNC_POL;
            vs_p_q  <= ~SYNC_POL;
            vid_p_q <= 1'b0;
        end else if (tick) begin
            hs_p_q  <= hs_q;
            vs_p_q  <= vs_q;
            vid_p_q <= vid_q;
        end
    end

    assign horiz_sync = hs_p_q;
    assign vert_sync  = vs_p_q;
    assign video_on   = vid_p_q;
`else
    assign horiz_sync = hs_q;
    assign vert_sync  = vs_q;
    assign video_on   = vid_q;
`endif

    // Strobes are forced low in any clock where the generator is paused.
    assign pix_en       = pix_q & en;
    assign line_start   = ls_q & en;
    assign frame_start  = fs_q & en;
    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign col_scaled   = colsc_q;
    assign row_scaled   = rowsc_q;
    assign frame_count  = fc_q;
endmodule
